// File: rtl/dsp_pkg.sv
// Shared types and helpers for the multi-channel DSP MAC engine.
// Optional saturation is selected by the DSP_MAC_SATURATE_EN macro in the top.
package dsp_pkg;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_MULC = 2'b01,
        OP_ACC  = 2'b10,
        OP_SUB  = 2'b11
    } opmode_e;

    // MSB patterns used to build the saturation limits at any width
    localparam logic SAT_POS_MSB = 1'b0;
    localparam logic SAT_NEG_MSB = 1'b1;

    function automatic int ch_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/dsp_mult_pipe.sv
// Signed A*B multiplier with STAGES pipeline registers and a common enable.
// A sideband bus travels alongside the product so it stays beat-aligned.
module dsp_mult_pipe #(
    parameter int A_W    = 25,
    parameter int B_W    = 18,
    parameter int SB_W   = 1,
    parameter int STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    in_valid,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    input  logic [SB_W-1:0]         in_sb,
    output logic                    out_valid,
    output logic signed [A_W+B_W-1:0] out_prod,
    output logic [SB_W-1:0]         out_sb
);

    localparam int PW = A_W + B_W;

    logic signed [PW-1:0] prod_q  [STAGES];
    logic                 valid_q [STAGES];
    logic [SB_W-1:0]      sb_q    [STAGES];

    // Product, valid and sideband shift one stage per enabled cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                prod_q[i]  <= '0;
                valid_q[i] <= 1'b0;
                sb_q[i]    <= '0;
            end
        end else if (en) begin
            prod_q[0]  <= PW'(a) * PW'(b);
            valid_q[0] <= in_valid;
            sb_q[0]    <= in_sb;
            for (int i = 1; i < STAGES; i++) begin
                prod_q[i]  <= prod_q[i-1];
                valid_q[i] <= valid_q[i-1];
                sb_q[i]    <= sb_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign out_prod  = prod_q[STAGES-1];
    assign out_sb    = sb_q[STAGES-1];

endmodule

// File: rtl/dsp_mac_engine.sv
// Multi-channel signed MAC: multiplier pipe, per-channel accumulators, pattern detect.
// Define DSP_MAC_SATURATE_EN to clamp overflowing results instead of wrapping.
module dsp_mac_engine
    import dsp_pkg::*;
#(
    parameter int A_W      = 25,
    parameter int B_W      = 18,
    parameter int P_W      = 48,
    parameter int M_STAGES = 2,
    parameter int CHANNELS = 4,
    localparam int CH_W    = ch_w(CHANNELS)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [CH_W-1:0]       IN_CH,
    input  logic                  IN_LAST,
    input  logic [1:0]            OPMODE,
    input  logic signed [A_W-1:0] A,
    input  logic signed [B_W-1:0] B,
    input  logic signed [P_W-1:0] C,
    input  logic [P_W-1:0]        PATTERN,
    input  logic [P_W-1:0]        MASK,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic signed [P_W-1:0] OUT_P,
    output logic [CH_W-1:0]       OUT_CH,
    output logic                  OUT_LAST,
    output logic                  OVERFLOW,
    output logic                  PATTERN_DETECT
);

    localparam int SB_W = 2 + CH_W + 1 + P_W;
    localparam int ACC_N = 2 ** CH_W;

    localparam logic [P_W-1:0] P_MAX = {SAT_POS_MSB, {(P_W-1){SAT_NEG_MSB}}};
    localparam logic [P_W-1:0] P_MIN = {SAT_NEG_MSB, {(P_W-1){SAT_POS_MSB}}};

    logic                      advance;
    logic                      m_valid;
    logic signed [A_W+B_W-1:0] m_prod;
    logic [SB_W-1:0]           m_sb;
    logic [1:0]                m_op;
    logic [CH_W-1:0]           m_ch;
    logic                      m_last;
    logic signed [P_W-1:0]     m_c;
    logic                      in_range;
    logic                      acc_we;

    logic signed [P_W-1:0] acc [ACC_N];

    opmode_e               op;
    logic signed [P_W-1:0] prod_ext;
    logic signed [P_W-1:0] acc_rd;
    logic signed [P_W-1:0] opa;
    logic signed [P_W-1:0] opb;
    logic signed [P_W-1:0] sum;
    logic signed [P_W-1:0] res;
    logic                  ovf;
    logic                  pd;

    // One global stall: nothing moves while a result waits for the consumer
    assign advance  = !OUT_VALID || OUT_READY;
    assign IN_READY = advance;

    dsp_mult_pipe #(
        .A_W    (A_W),
        .B_W    (B_W),
        .SB_W   (SB_W),
        .STAGES (M_STAGES)
    ) u_mult (
        .clk       (CLK),
        .rst       (RST),
        .en        (advance),
        .in_valid  (IN_VALID),
        .a         (A),
        .b         (B),
        .in_sb     ({OPMODE, IN_CH, IN_LAST, C}),
        .out_valid (m_valid),
        .out_prod  (m_prod),
        .out_sb    (m_sb)
    );

    assign {m_op, m_ch, m_last, m_c} = m_sb;
    assign in_range = int'(m_ch) < CHANNELS;
    assign acc_we   = advance && m_valid && in_range;

    // ALU: pick addends by mode, add modulo 2^P_W, flag signed overflow
    always_comb begin
        op       = opmode_e'(m_op);
        prod_ext = P_W'(m_prod);
        acc_rd   = in_range ? acc[m_ch] : '0;
        opa      = '0;
        opb      = prod_ext;
        unique case (op)
            OP_MUL:  opa = '0;
            OP_MULC: opa = m_c;
            OP_ACC:  opa = acc_rd;
            OP_SUB: begin
                opa = acc_rd;
                opb = -prod_ext;
            end
        endcase
        sum = opa + opb;
        ovf = (opa[P_W-1] == opb[P_W-1]) && (sum[P_W-1] != opa[P_W-1]);
`ifdef DSP_MAC_SATURATE_EN
        res = ovf ? (opa[P_W-1] ? P_MIN : P_MAX) : sum;
`else
        res = sum;
`endif
        pd = ((res ^ PATTERN) & ~MASK) == '0;
    end

    // Accumulator update on retire; IN_LAST restarts the channel from zero
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < ACC_N; i++) begin
                acc[i] <= '0;
            end
        end else if (acc_we) begin
            acc[m_ch] <= m_last ? '0 : res;
        end
    end

    // Output register holds everything while the consumer stalls
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OUT_VALID      <= 1'b0;
            OUT_P          <= '0;
            OUT_CH         <= '0;
            OUT_LAST       <= 1'b0;
            OVERFLOW       <= 1'b0;
            PATTERN_DETECT <= 1'b0;
        end else if (advance) begin
            OUT_VALID <= m_valid;
            if (m_valid) begin
                OUT_P          <= res;
                OUT_CH         <= m_ch;
                OUT_LAST       <= m_last;
                OVERFLOW       <= ovf;
                PATTERN_DETECT <= pd;
            end
        end
    end

endmodule

// File: tb/tb_dsp_mac_engine.sv
// Scoreboard bench for dsp_mac_engine (default parameters).
// Honours DSP_MAC_SATURATE_EN for overflow expectations.
module tb_dsp_mac_engine;

    localparam longint P_MAX = 64'sh0000_7FFF_FFFF_FFFF;
    localparam longint P_MIN = -64'sh0000_8000_0000_0000;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         in_ch;
    logic               in_last;
    logic [1:0]         opmode;
    logic signed [24:0] a;
    logic signed [17:0] b;
    logic signed [47:0] c;
    logic [47:0]        pattern;
    logic [47:0]        mask;
    logic               out_valid;
    logic               out_ready;
    logic [47:0]        out_p;
    logic [1:0]         out_ch;
    logic               out_last;
    logic               ovf;
    logic               pd;

    typedef struct packed {
        logic [47:0] p;
        logic [1:0]  ch;
        logic        last;
        logic        ovf;
        logic        pd;
    } exp_t;

    exp_t   sbq[$];
    exp_t   mon_e;
    int     tests_run = 0;
    int     failed = 0;
    longint acc_m[4];

    dsp_mac_engine dut (
        .CLK            (clk),
        .RST            (rst),
        .IN_VALID       (in_valid),
        .IN_READY       (in_ready),
        .IN_CH          (in_ch),
        .IN_LAST        (in_last),
        .OPMODE         (opmode),
        .A              (a),
        .B              (b),
        .C              (c),
        .PATTERN        (pattern),
        .MASK           (mask),
        .OUT_VALID      (out_valid),
        .OUT_READY      (out_ready),
        .OUT_P          (out_p),
        .OUT_CH         (out_ch),
        .OUT_LAST       (out_last),
        .OVERFLOW       (ovf),
        .PATTERN_DETECT (pd)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Scoreboard: compare each result as the consumer takes it
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            tests_run++;
            if (sbq.size() == 0) begin
                failed++;
                $display("FAIL unexpected_out: got p=%0h ch=%0d, need no output",
                         out_p, out_ch);
            end else begin
                mon_e = sbq.pop_front();
                if ({out_p, out_ch, out_last, ovf, pd} !== mon_e) begin
                    failed++;
                    $display("FAIL scoreboard: got p=%0h ch=%0d last=%0b ovf=%0b pd=%0b, need p=%0h ch=%0d last=%0b ovf=%0b pd=%0b",
                             out_p, out_ch, out_last, ovf, pd,
                             mon_e.p, mon_e.ch, mon_e.last, mon_e.ovf, mon_e.pd);
                end
            end
        end
    end

    function automatic longint sx48(input logic [47:0] v);
        return longint'($signed(v));
    endfunction

    task automatic send(input logic [1:0] op, input int ch, input logic last,
                        input longint av, input longint bv, input longint cv,
                        input longint ep, input logic eovf);
        exp_t e;
        logic [47:0] p48;
        int n;
        p48    = ep[47:0];
        e.p    = p48;
        e.ch   = ch[1:0];
        e.last = last;
        e.ovf  = eovf;
        e.pd   = (((p48 ^ pattern) & ~mask) == 48'd0);
        sbq.push_back(e);
        acc_m[ch] = last ? 64'sd0 : sx48(p48);
        in_valid = 1'b1;
        opmode   = op;
        in_ch    = ch[1:0];
        in_last  = last;
        a        = av[24:0];
        b        = bv[17:0];
        c        = cv[47:0];
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests_run++;
            failed++;
            $display("FAIL in_ready_timeout: got 0, need 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [1:0] op, input int ch, input logic last,
                              input longint av, input longint bv, input longint cv);
        longint prod;
        longint x;
        longint full;
        longint ep;
        logic   eo;
        prod = av * bv;
        x = (op == 2'b00) ? 64'sd0 : (op == 2'b01) ? cv : acc_m[ch];
        full = (op == 2'b11) ? x - prod : x + prod;
        eo = (full > P_MAX) || (full < P_MIN);
        ep = full;
        if (eo) begin
`ifdef DSP_MAC_SATURATE_EN
            ep = (full > P_MAX) ? P_MAX : P_MIN;
`else
            ep = sx48(full[47:0]);
`endif
        end
        send(op, ch, last, av, bv, cv, ep, eo);
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (sbq.size() != 0) begin
            failed++;
            $display("FAIL drain: got %0d pending results, need 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic test_reset;
        tests_run++;
        if (out_valid !== 1'b0 || out_p !== 48'd0) begin
            failed++;
            $display("FAIL poweron_reset: got valid=%0b p=%0h, need 0/0", out_valid, out_p);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send(2'b10, 0, 1'b0, 3, 3, 0, 9, 1'b0);
        send(2'b10, 0, 1'b0, 3, 3, 0, 18, 1'b0);
        send(2'b10, 0, 1'b0, 3, 3, 0, 27, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_p !== 48'd0) begin
            failed++;
            $display("FAIL midstream_reset: got valid=%0b p=%0h, need 0/0", out_valid, out_p);
        end
        sbq.delete();
        foreach (acc_m[i]) acc_m[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send(2'b10, 0, 1'b1, 1, 1, 0, 1, 1'b0);
        drain();
    endtask

    task automatic test_mult;
        int lat;
        send(2'b00, 0, 1'b1, -2, -4, 0, 8, 1'b0);
        lat = 1;
        begin : wait_out
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (out_valid) disable wait_out;
                lat++;
            end
        end
        tests_run++;
        if (lat != 3 || out_p !== 48'd8) begin
            failed++;
            $display("FAIL mult_latency: got lat=%0d p=%0h, need lat=3 p=8", lat, out_p);
        end
        drain();
    endtask

    task automatic test_accumulate;
        send(2'b10, 0, 1'b0, 3, 5, 0, 15, 1'b0);
        send(2'b10, 0, 1'b0, 3, 5, 0, 30, 1'b0);
        send(2'b10, 0, 1'b0, 3, 5, 0, 45, 1'b0);
        send(2'b10, 0, 1'b1, 3, 5, 0, 60, 1'b0);
        send(2'b10, 0, 1'b1, 1, 1, 0, 1, 1'b0);
        drain();
    endtask

    task automatic test_interleave;
        send(2'b10, 0, 1'b0, 2, 2, 0, 4, 1'b0);
        send(2'b10, 1, 1'b0, -1, 7, 0, -7, 1'b0);
        send(2'b10, 0, 1'b1, 2, 2, 0, 8, 1'b0);
        send(2'b10, 1, 1'b1, -1, 7, 0, -14, 1'b0);
        drain();
    endtask

    task automatic test_backpressure;
        logic [47:0] held;
        fork
            begin
                for (int i = 0; i < 14; i++) begin
                    send_model(2'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                               ($urandom_range(0, 3) == 0),
                               longint'($urandom_range(0, 100)) - 50,
                               longint'($urandom_range(0, 100)) - 50,
                               longint'($urandom_range(0, 2000)) - 1000);
                end
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                held = out_p;
                tests_run++;
                if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                    failed++;
                    $display("FAIL stall_start: got valid=%0b in_ready=%0b, need 1/0",
                             out_valid, in_ready);
                end
                for (int i = 1; i < 5; i++) begin
                    @(negedge clk);
                    tests_run++;
                    if (in_ready !== 1'b0 || out_p !== held) begin
                        failed++;
                        $display("FAIL stall_hold: got in_ready=%0b p=%0h, need 0 p=%0h",
                                 in_ready, out_p, held);
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
    endtask

    task automatic test_overflow_pattern;
`ifdef DSP_MAC_SATURATE_EN
        send(2'b01, 2, 1'b0, 0, 0, P_MAX, P_MAX, 1'b0);
        send(2'b10, 2, 1'b1, 1, 1, 0, P_MAX, 1'b1);
        send(2'b01, 3, 1'b0, 0, 0, P_MIN, P_MIN, 1'b0);
        send(2'b11, 3, 1'b1, 1, 1, 0, P_MIN, 1'b1);
`else
        send(2'b01, 2, 1'b0, 0, 0, P_MAX, P_MAX, 1'b0);
        send(2'b10, 2, 1'b1, 1, 1, 0, P_MIN, 1'b1);
        send(2'b01, 3, 1'b0, 0, 0, P_MIN, P_MIN, 1'b0);
        send(2'b11, 3, 1'b1, 1, 1, 0, P_MAX, 1'b1);
`endif
        drain();
        pattern = 48'h1234;
        mask    = 48'h0;
        send(2'b01, 0, 1'b1, 0, 5, 48'h1234, 48'h1234, 1'b0);
        send(2'b01, 0, 1'b1, 0, 5, 48'h1235, 48'h1235, 1'b0);
        drain();
        pattern = 48'h1200;
        mask    = 48'hFF;
        send(2'b01, 1, 1'b1, 0, 0, 48'h1234, 48'h1234, 1'b0);
        send(2'b01, 1, 1'b1, 0, 0, 48'h1334, 48'h1334, 1'b0);
        drain();
        pattern = 48'h0;
        mask    = 48'h0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_ch     = '0;
        in_last   = 1'b0;
        opmode    = '0;
        a         = '0;
        b         = '0;
        c         = '0;
        pattern   = '0;
        mask      = '0;
        out_ready = 1'b1;
        foreach (acc_m[i]) acc_m[i] = 0;
        #1;
        test_reset();
        test_mult();
        test_accumulate();
        test_interleave();
        test_backpressure();
        test_overflow_pattern();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
